// File: rtl/led_frame_scheduler.sv
// Frame sequencer for a WS2812 serializer: reads one frame of RGB pixels from a
// double-banked RAM, scales by brightness, reorders to GRB and streams words.
module led_frame_scheduler #(
  parameter int          N_LEDS       = 60,
  parameter int          ADDR_W       = 6,
  parameter logic [31:0] GAP_CYCLES   = 32'd30000,
  parameter logic [31:0] FRAME_PERIOD = 32'd1666666
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              auto_en,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic [7:0]        brightness,
  input  logic              swap_req,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic [23:0]       m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, GAP} state_t;

  localparam logic [ADDR_W:0] N_MAX = (ADDR_W+1)'(N_LEDS);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] TWO   = (ADDR_W+1)'(2);

  state_t            state, state_next;
  logic [ADDR_W:0]   len_r, len_in, idx, acc_cnt;
  logic [7:0]        bri_r;
  logic [31:0]       timer, gap_cnt;
  logic              pending, swap_pend;
  logic              expiry, trig_evt, trig, capture, accept;
  logic              vld_p0;
  logic [23:0]       fifo_mem_p1 [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt, cnt_next, fill_target;

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] prod;
    prod = {9'd0, c} * ({9'd0, b} + 17'd1);
    return 8'(prod >> 8);
  endfunction

  assign expiry      = auto_en && (timer == FRAME_PERIOD - 32'd1);
  assign trig_evt    = start || expiry;
  assign trig        = trig_evt || pending;
  assign capture     = (state == IDLE) && trig;
  assign len_in      = (cfg_len > N_MAX) ? N_MAX : cfg_len;
  assign m_valid     = (state == STREAM) && (fifo_cnt != 2'd0);
  assign accept      = m_valid && m_ready;
  // Occupancy after this edge, counting the word already in flight from the RAM.
  assign cnt_next    = fifo_cnt + {1'b0, vld_p0} - {1'b0, accept};
  assign fill_target = (len_r >= TWO) ? 2'd2 : 2'd1;
  assign rd_en       = ((state == FILL) || (state == STREAM)) && (idx < len_r) &&
                       (cnt_next < 2'd2);
  assign rd_addr     = idx[ADDR_W-1:0];
  assign busy        = (state != IDLE);
  assign m_data      = m_valid ? fifo_mem_p1[rd_ptr] : 24'd0;

  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    case (state)
      IDLE:    if (trig && (len_in != '0)) state_next = FILL;
      FILL:    if (cnt_next >= fill_target) state_next = STREAM;
      STREAM:  if (accept && (acc_cnt + ONE == len_r)) state_next = GAP;
      GAP: begin
        if (gap_cnt == GAP_CYCLES - 32'd1) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_r     <= '0;
      idx       <= '0;
      acc_cnt   <= '0;
      timer     <= '0;
      gap_cnt   <= '0;
      pending   <= 1'b0;
      swap_pend <= 1'b0;
      rd_bank   <= 1'b0;
      overrun   <= 1'b0;
      vld_p0    <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
    end else begin
      state    <= state_next;
      vld_p0   <= rd_en;
      fifo_cnt <= cnt_next;
      timer    <= (!auto_en || expiry) ? 32'd0 : timer + 32'd1;
      gap_cnt  <= (state == GAP) ? gap_cnt + 32'd1 : 32'd0;
      if (rd_en)  idx     <= idx + ONE;
      if (accept) acc_cnt <= acc_cnt + ONE;
      if (vld_p0) wr_ptr  <= ~wr_ptr;
      if (accept) rd_ptr  <= ~rd_ptr;
      // Any IDLE cycle consumes the pending request; while busy, triggers queue up.
      if (state == IDLE)  pending <= 1'b0;
      else if (trig_evt)  pending <= 1'b1;
      if ((state != IDLE) && expiry) overrun <= 1'b1;
      swap_pend <= swap_req || (swap_pend && !capture);
      if (capture) begin
        len_r   <= len_in;
        idx     <= '0;
        acc_cnt <= '0;
        wr_ptr  <= 1'b0;
        rd_ptr  <= 1'b0;
        if (swap_pend) rd_bank <= ~rd_bank;
      end
    end
  end

  // Stage p1: scaled, reordered pixel word written into the FIFO.
  always_ff @(posedge clk) begin
    if (capture) bri_r <= brightness;
    if (vld_p0)
      fifo_mem_p1[wr_ptr] <= {scale(rd_data[15:8], bri_r), scale(rd_data[23:16], bri_r),
                              scale(rd_data[7:0], bri_r)};
  end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler: table of single-pixel scaling vectors
// plus hand sequences for streaming, bank swap, auto trigger and mid-frame reset.
module tb_led_frame_scheduler;

  localparam int GAP = 20;

  logic        clk = 1'b0;
  logic        rst, start, auto_en, swap_req, m_ready;
  logic [6:0]  cfg_len;
  logic [7:0]  brightness;
  logic        rd_en, rd_bank, m_valid, busy, frame_done, overrun;
  logic [5:0]  rd_addr;
  logic [23:0] rd_data, m_data;

  logic [23:0] ram [0:1][0:63];
  logic [23:0] got [0:63];

  int n_checks = 0, n_pass = 0;
  int n_acc, bubbles, done_lat, first_vld, first_acc, last_acc;
  int n_reads, addr_errs, bank_changes, hold_errs, word_errs;
  int found, busy_seen, rd_seen;

  typedef struct {
    logic [23:0] rgb;
    logic [7:0]  bri;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs [8];

  led_frame_scheduler #(
    .N_LEDS(60), .ADDR_W(6), .GAP_CYCLES(32'd20), .FRAME_PERIOD(32'd100)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .cfg_len(cfg_len),
    .brightness(brightness), .swap_req(swap_req), .rd_en(rd_en), .rd_bank(rd_bank),
    .rd_addr(rd_addr), .rd_data(rd_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= ram[rd_bank][rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_frame(input logic [6:0] len_cfg, input int exp_len, input logic [7:0] bri,
                           input int rp, input int swap_at);
    logic        bank0, prev_hold, done;
    logic [23:0] prev_data;
    n_acc = 0; bubbles = 0; done_lat = -1; first_vld = -1; first_acc = -1; last_acc = -1;
    n_reads = 0; addr_errs = 0; bank_changes = 0; hold_errs = 0;
    prev_hold = 1'b0; prev_data = '0; done = 1'b0;
    @(negedge clk);
    cfg_len = len_cfg; brightness = bri; start = 1'b1; m_ready = 1'b0;
    bank0 = rd_bank;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start    = 1'b0;
      swap_req = (i == swap_at);
      m_ready  = (rp == 1) ? 1'b1 : ((i % rp) == rp - 1);
      #1;
      if (m_valid && first_vld < 0) first_vld = i;
      if (rd_en) begin
        if (int'(rd_addr) != n_reads) addr_errs++;
        n_reads++;
      end
      if (rd_bank != bank0) bank_changes++;
      if (prev_hold && m_data != prev_data) hold_errs++;
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      if (m_valid && m_ready) begin
        if (n_acc < 64) got[n_acc] = m_data;
        if (n_acc == 0) first_acc = i;
        last_acc = i;
        n_acc++;
      end else if (first_vld >= 0 && n_acc < exp_len && !m_valid) begin
        bubbles++;
      end
      if (frame_done) begin
        done_lat = i - last_acc;
        done = 1'b1;
        break;
      end
    end
    swap_req = 1'b0;
    m_ready  = 1'b0;
    check("frame_completes", done, 1'b1);
  endtask

  initial begin
    vecs[0] = '{24'hFF0000, 8'd255, 24'h00FF00};
    vecs[1] = '{24'h808080, 8'd127, 24'h404040};
    vecs[2] = '{24'h808080, 8'd0,   24'h000000};
    vecs[3] = '{24'h123456, 8'd255, 24'h341256};
    vecs[4] = '{24'hFFFFFF, 8'd128, 24'h808080};
    vecs[5] = '{24'hC86432, 8'd63,  24'h19320C};
    vecs[6] = '{24'hFFFFFF, 8'd1,   24'h010101};
    vecs[7] = '{24'h010203, 8'd255, 24'h020103};

    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 64; a++) ram[b][a] = 24'h0;

    rst = 1'b1; start = 1'b0; auto_en = 1'b0; swap_req = 1'b0; m_ready = 1'b0;
    cfg_len = '0; brightness = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_bank", rd_bank, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_m_data", m_data, 0);
    rst = 1'b0;

    // Three pixels, slow serializer: GRB order, unbroken valid, gap timing.
    ram[0][0] = 24'hFF0000; ram[0][1] = 24'h00FF00; ram[0][2] = 24'h0000FF;
    run_frame(7'd3, 3, 8'd255, 24, -1);
    check("t1_n_acc", n_acc, 3);
    check("t1_word0", got[0], 24'h00FF00);
    check("t1_word1", got[1], 24'hFF0000);
    check("t1_word2", got[2], 24'h0000FF);
    check("t1_first_valid_lat", first_vld, 3);
    check("t1_bubbles", bubbles, 0);
    check("t1_hold", hold_errs, 0);
    check("t1_done_lat", done_lat, GAP);
    check("t1_reads", n_reads, 3);

    for (int v = 0; v < 8; v++) begin
      ram[0][0] = vecs[v].rgb;
      ram[1][0] = vecs[v].rgb;
      run_frame(7'd1, 1, vecs[v].bri, 1, -1);
      check($sformatf("vec%0d_n_acc", v), n_acc, 1);
      check($sformatf("vec%0d_word", v), got[0], vecs[v].exp);
    end

    // Full-length frame with constant ready; cfg_len above N_LEDS clamps to 60.
    for (int a = 0; a < 60; a++) ram[0][a] = {8'(a), 8'(a * 3), 8'(255 - a)};
    run_frame(7'd70, 60, 8'd255, 1, -1);
    word_errs = 0;
    for (int a = 0; a < 60; a++)
      if (got[a] !== {8'(a * 3), 8'(a), 8'(255 - a)}) word_errs++;
    check("t6_n_acc", n_acc, 60);
    check("t6_word_errs", word_errs, 0);
    check("t6_back_to_back", last_acc - first_acc, 59);
    check("t6_bubbles", bubbles, 0);
    check("t6_reads", n_reads, 60);
    check("t6_addr_order", addr_errs, 0);

    // Swap requested mid-frame is deferred; a zero-length start still applies it.
    ram[0][0] = 24'h0A0B0C; ram[0][1] = 24'h0D0E0F; ram[0][2] = 24'h112233;
    run_frame(7'd3, 3, 8'd255, 4, 5);
    check("t3_bank_stable", bank_changes, 0);
    check("t3_bank_during", rd_bank, 0);
    check("t3_n_acc", n_acc, 3);
    @(negedge clk);
    cfg_len = 7'd0; start = 1'b1;
    busy_seen = 0; rd_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (busy) busy_seen++;
      if (rd_en) rd_seen++;
    end
    check("t3_len0_busy", busy_seen, 0);
    check("t3_len0_reads", rd_seen, 0);
    check("t3_bank_toggled", rd_bank, 1);

    // Auto trigger with a frame longer than the period.
    check("t4_overrun_pre", overrun, 0);
    cfg_len = 7'd3; brightness = 8'd255; auto_en = 1'b1;
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      @(negedge clk);
      m_ready = ((i % 50) == 49);
      #1;
      if (frame_done) found = 1;
    end
    check("t4_first_done", found, 1);
    check("t4_overrun", overrun, 1);
    @(negedge clk);
    m_ready = 1'b0; auto_en = 1'b0;
    #1;
    check("t4_idle_after_done", busy, 0);
    @(negedge clk);
    #1;
    check("t4_pending_started", busy, 1);
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      @(negedge clk);
      m_ready = ((i % 50) == 49);
      #1;
      if (frame_done) found = 1;
    end
    m_ready = 1'b0;
    check("t4_second_done", found, 1);

    // Reset while streaming from bank 1, then replay from bank 0 index 0.
    ram[0][0] = 24'hA1B2C3; ram[0][1] = 24'h102030; ram[0][2] = 24'h0F0E0D;
    ram[1][0] = 24'h555555; ram[1][1] = 24'h666666; ram[1][2] = 24'h777777;
    ram[1][3] = 24'h888888; ram[1][4] = 24'h999999;
    @(negedge clk);
    cfg_len = 7'd5; brightness = 8'd255; start = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (m_valid) found = 1;
    end
    check("t5_reached_stream", found, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_m_valid", m_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_rd_bank", rd_bank, 0);
    check("t5_overrun_cleared", overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    run_frame(7'd3, 3, 8'd255, 1, -1);
    check("t5_n_acc", n_acc, 3);
    check("t5_word0", got[0], 24'hB2A1C3);
    check("t5_word1", got[1], 24'h201030);
    check("t5_word2", got[2], 24'h0E0F0D);
    check("t5_first_valid_lat", first_vld, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
